dmem_responder: RTL and testbench

Multi-cycle data-memory responder that sits on the MEM-stage side of the pipelined core and replaces the single-cycle data memory. It takes the MEM stage's read/write strobes, address and store data, and holds the pipeline with `stall` for a fixed, parameterised access latency. It completes each access from an internal word-addressed RAM and returns load data with a one-cycle valid pulse. It also flags misaligned, out-of-range and conflicting accesses.

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Stalls the pipeline for LATENCY cycles per access and flags faults.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic ONE_CYCLE = (LATENCY == 1);

  state_t r_state;
  logic [3:0] r_cnt;
  logic r_rd;
  logic r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] mem [2**DEPTH_LOG2];

  logic w_idle;
  logic w_req;
  logic w_rd;
  logic w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic w_fault;
  logic w_enter_done;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = req_read | req_write;

  // With LATENCY==1 the access completes on the accept edge itself,
  // so the live request is used instead of the latched copy.
  assign w_rd    = w_idle ? req_read  : r_rd;
  assign w_wr    = w_idle ? req_write : r_wr;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_idx   = w_addr[DEPTH_LOG2+1:2];

  assign w_fault = (w_addr[1:0] != 2'b00)
                 | ((w_addr >> (DEPTH_LOG2 + 2)) != '0)
                 | (w_rd & w_wr);

  assign w_enter_done =
      (w_idle & w_req & ONE_CYCLE)
    | ((r_state == S_WAIT) & (r_cnt == 4'd0));

  assign stall = ~rst & ((w_idle & w_req) | (r_state == S_WAIT));
  assign busy  = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst && w_enter_done && w_wr && !w_fault)
      mem[w_idx] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      if (w_enter_done) begin
        if (w_fault) begin
          rdata <= '0;
          err   <= 1'b1;
        end else if (w_rd) begin
          rdata       <= mem[w_idx];
          rdata_valid <= 1'b1;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_rd    <= req_read;
            r_wr    <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (ONE_CYCLE) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= S_DONE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 1..4.
// Random and directed accesses checked against a word-level model.
module tb_dmem_responder;

  localparam int D = 8;

  typedef struct {
    logic        err;
    logic        vld;
    logic [31:0] data;
    logic        chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int lat,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (LATENCY=%0d) got %h expected %h",
               name, lat, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_l
    localparam int L = g + 1;

    logic rst, rd, wr, stall, vld, err, busy, fin;
    logic [31:0] addr, wdata, rdata;

    dmem_responder #(.DEPTH_LOG2(D), .LATENCY(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_read   (rd),
      .req_write  (wr),
      .req_addr   (addr),
      .req_wdata  (wdata),
      .stall      (stall),
      .rdata      (rdata),
      .rdata_valid(vld),
      .err        (err),
      .busy       (busy)
    );

    exp_t q[$];
    logic [31:0] m [int];
    logic [31:0] last;
    logic last_ok;

    function automatic logic is_fault(input logic r, input logic w,
                                      input logic [31:0] a);
      return (a % 4 != 0) || (a >= (32'd4 << D)) || (r && w);
    endfunction

    task automatic expect_push(input logic r, input logic w,
                               input logic [31:0] a,
                               input logic [31:0] d);
      exp_t e;
      int i;
      i = int'(a / 4);
      if (is_fault(r, w, a)) begin
        e = '{1'b1, 1'b0, 32'd0, 1'b1};
        last = 32'd0;
        last_ok = 1'b1;
      end else if (r) begin
        if (m.exists(i)) begin
          e = '{1'b0, 1'b1, m[i], 1'b1};
          last = m[i];
          last_ok = 1'b1;
        end else begin
          e = '{1'b0, 1'b1, 32'd0, 1'b0};
          last_ok = 1'b0;
        end
      end else begin
        m[i] = d;
        e = '{1'b0, 1'b0, last, last_ok};
      end
      q.push_back(e);
    endtask

    // Called just after a rising edge with the DUT in IDLE.
    task automatic access(input logic r, input logic w,
                          input logic [31:0] a,
                          input logic [31:0] d);
      int n;
      rd = r;
      wr = w;
      addr = a;
      wdata = d;
      expect_push(r, w, a, d);
      #1;
      check("stall_on_accept", L, stall, 1);
      n = 1;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (!stall) break;
        n++;
      end
      check("stall_length", L, n, L);
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
    endtask

    always @(posedge clk) begin
      exp_t e;
      #2;
      if (busy && !stall) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done (LATENCY=%0d) got completion expected none", L);
        end else begin
          e = q.pop_front();
          check("err", L, err, e.err);
          check("rdata_valid", L, vld, e.vld);
          if (e.chk) check("rdata", L, rdata, e.data);
        end
      end else begin
        check("no_pulse_outside_done", L, {vld, err}, 0);
      end
    end

    initial begin
      int periods, comps, kk, sel, op;
      logic [31:0] a;
      fin = 1'b0;
      rst = 1'b1;
      rd = 1'b1;
      wr = 1'b0;
      addr = 32'h40;
      wdata = 32'd0;
      last = 32'd0;
      last_ok = 1'b1;
      @(posedge clk);
      #1;
      check("reset_stall", L, stall, 0);
      check("reset_busy", L, busy, 0);
      check("reset_rdata", L, rdata, 0);
      check("reset_valid", L, vld, 0);
      check("reset_err", L, err, 0);
      rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      access(0, 1, 32'h40, 32'hDEAD_BEEF);
      access(1, 0, 32'h40, 0);
      access(0, 1, 32'h0, 32'h1);
      access(1, 0, 32'h0, 0);
      access(0, 1, 32'h3FC, 32'h2);
      access(1, 0, 32'h3FC, 0);
      access(0, 1, 32'h10, 32'h1234_5678);
      access(1, 0, 32'h42, 0);
      access(1, 0, 32'h400, 0);
      access(1, 1, 32'h10, 32'hFFFF_FFFF);
      access(0, 1, 32'h12, 32'h0000_0BAD);
      access(0, 1, 32'hFFFF_FFF0, 32'h0000_0BAD);
      access(1, 0, 32'h10, 0);

      // Abort a write one cycle after accept; only LATENCY==1 has committed.
      access(0, 1, 32'h80, 32'hAA);
      wr = 1'b1;
      addr = 32'h80;
      wdata = 32'h55;
      @(posedge clk);
      #1;
      check("abort_busy", L, busy, 1);
      check("abort_stall", L, stall, L > 1);
      rst = 1'b1;
      #1;
      check("async_rst_stall", L, stall, 0);
      check("async_rst_busy", L, busy, 0);
      check("async_rst_rdata", L, rdata, 0);
      check("async_rst_valid", L, vld, 0);
      check("async_rst_err", L, err, 0);
      if (L == 1) m[32] = 32'h55;
      last = 32'd0;
      last_ok = 1'b1;
      wr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      access(1, 0, 32'h80, 0);

      // Strobe held high: LATENCY stalled cycles, DONE, repeat.
      periods = 8 / (L + 1) + 1;
      rd = 1'b1;
      wr = 1'b0;
      addr = 32'h40;
      for (int p = 0; p < periods; p++) expect_push(1, 0, 32'h40, 0);
      comps = 0;
      for (int k = 0; k < periods * (L + 1); k++) begin
        #1;
        kk = k % (L + 1);
        check("held_stall", L, stall, kk != L);
        check("held_busy", L, busy, kk != 0);
        if (busy && !stall && k < 8) comps++;
        @(posedge clk);
        #1;
      end
      rd = 1'b0;
      check("held_completions_8", L, comps, 8 / (L + 1));

      for (int t = 0; t < 150; t++) begin
        sel = $urandom_range(0, 9);
        op = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15)) * 4;
        if (sel == 0) a = a | 32'($urandom_range(1, 3));
        if (sel == 1) a = a | 32'h400 | ($urandom & 32'hFFFF_FC00);
        if (sel == 2) a = 32'h3FC;
        access(op < 5, op >= 5, a, $urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", L, q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    wait (g_l[0].fin && g_l[1].fin && g_l[2].fin && g_l[3].fin);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion of all stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
